// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/acknowledge bus between the fetch sequencer and
// the instruction memory: one request outstanding, a single-cycle ack returns its data.
interface fetch_sequencer_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: owns the fetch PC, issues one instruction-memory request at a
// time, buffers one word across decode stalls and absorbs redirects while a request is in flight.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          TIMEOUT   = 16,
  parameter int          TO_WIDTH  = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pc_src_e,
  input  logic [31:0]              pc_target_e,
  input  logic                     stall_d,
  fetch_sequencer_if.master        imem,
  output logic [31:0]              instr_f,
  output logic [31:0]              pc_out_f,
  output logic [31:0]              pc_plus4_f,
  output logic                     valid_f,
  output logic                     fetch_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

  localparam logic [TO_WIDTH-1:0] TO_MAX = TO_WIDTH'(TIMEOUT);

  state_t              state, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [31:0]         drop_addr, drop_d;
  logic [31:0]         buf_q, buf_d;
  logic [TO_WIDTH-1:0] to_cnt, to_inc;
  logic                mem_req;
  logic [31:0]         mem_addr;
  logic                req_pending;

  // Next-state and output decode
  always_comb begin
    state_d  = state;
    pc_d     = pc_q;
    drop_d   = drop_addr;
    buf_d    = buf_q;
    mem_req  = 1'b0;
    mem_addr = pc_q;
    valid_f  = 1'b0;
    instr_f  = NOP_INSTR;
    pc_out_f = pc_q;

    unique case (state)
      IDLE: begin
        state_d = WAIT;
      end

      WAIT: begin
        mem_req = 1'b1;
        if (imem.mem_ack) begin
          if (pc_src_e) begin
            pc_d = pc_target_e;
          end else if (!stall_d) begin
            valid_f = 1'b1;
            instr_f = imem.mem_rdata;
            pc_d    = pc_q + 32'd4;
          end else begin
            buf_d   = imem.mem_rdata;
            state_d = HOLD;
          end
        end else if (pc_src_e) begin
          // The in-flight request cannot be cancelled; remember it so its ack is swallowed.
          drop_d  = pc_q;
          pc_d    = pc_target_e;
          state_d = DROP;
        end
      end

      HOLD: begin
        if (pc_src_e) begin
          pc_d    = pc_target_e;
          state_d = WAIT;
        end else begin
          valid_f = 1'b1;
          instr_f = buf_q;
          if (!stall_d) begin
            pc_d    = pc_q + 32'd4;
            state_d = WAIT;
          end
        end
      end

      DROP: begin
        mem_req  = 1'b1;
        mem_addr = drop_addr;
        if (pc_src_e) pc_d = pc_target_e;
        if (imem.mem_ack) state_d = WAIT;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem.mem_req  = mem_req;
  assign imem.mem_addr = mem_addr;
  assign pc_plus4_f    = pc_out_f + 32'd4;

  assign req_pending = mem_req && !imem.mem_ack;
  assign to_inc      = (to_cnt == TO_MAX) ? to_cnt : to_cnt + TO_WIDTH'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      pc_q          <= RESET_PC;
      buf_q         <= NOP_INSTR;
      to_cnt        <= '0;
      fetch_timeout <= 1'b0;
    end else begin
      state  <= state_d;
      pc_q   <= pc_d;
      buf_q  <= buf_d;
      to_cnt <= req_pending ? to_inc : '0;
      if (req_pending && (to_inc == TO_MAX)) fetch_timeout <= 1'b1;
    end
  end

  // The abandoned address is only read in DROP, which is always entered through a write.
  always_ff @(posedge clk) begin
    drop_addr <= drop_d;
  end

`ifndef SYNTHESIS
  a_addr_stable: assert property (@(posedge clk) disable iff (!reset)
    (imem.mem_req && !imem.mem_ack) |=> (imem.mem_req && $stable(imem.mem_addr)));

  a_no_valid_on_redirect: assert property (@(posedge clk) disable iff (!reset)
    pc_src_e |-> !valid_f);
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios with literal expectations, then randomized
// memory latency, stalls and redirects, all checked every cycle against a behavioural model.
module tb_fetch_sequencer;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          TO  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic        stall_d;
  logic [31:0] instr_f, pc_out_f, pc_plus4_f;
  logic        valid_f, fetch_timeout;

  fetch_sequencer_if imem();

  fetch_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .pc_src_e      (pc_src_e),
    .pc_target_e   (pc_target_e),
    .stall_d       (stall_d),
    .imem          (imem.master),
    .instr_f       (instr_f),
    .pc_out_f      (pc_out_f),
    .pc_plus4_f    (pc_plus4_f),
    .valid_f       (valid_f),
    .fetch_timeout (fetch_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: "started" means the first request has been issued since reset;
  // a fetched word is either delivered, held for decode, or (if wrong-path) discarded.
  bit          m_started, m_held, m_disc, m_flag;
  logic [31:0] m_pc, m_word, m_drop;
  int          m_cnt;

  // Memory responder state for the random phase.
  bit mb;
  int ml;

  logic        s_valid;
  logic [31:0] s_instr, s_pc, s_pc4;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_held = 0; m_disc = 0; m_flag = 0;
    m_pc = 32'h0; m_word = NOP; m_drop = 32'h0; m_cnt = 0;
    mb = 0; ml = 0;
  endtask

  task automatic step(input bit ack, input logic [31:0] rd, input bit src,
                      input logic [31:0] tgt, input bit stl);
    bit          e_req, e_valid;
    logic [31:0] e_addr, e_instr;
    int          c;
    imem.mem_ack   = ack;
    imem.mem_rdata = rd;
    pc_src_e       = src;
    pc_target_e    = tgt;
    stall_d        = stl;
    @(negedge clk);
    e_req   = m_started && !m_held;
    e_addr  = m_disc ? m_drop : m_pc;
    e_valid = 0;
    e_instr = NOP;
    if (m_held && !src) begin
      e_valid = 1; e_instr = m_word;
    end else if (e_req && !m_disc && ack && !src && !stl) begin
      e_valid = 1; e_instr = rd;
    end
    chk("mem_req", imem.mem_req, e_req);
    if (e_req) chk("mem_addr", imem.mem_addr, e_addr);
    chk("valid_f", valid_f, e_valid);
    chk("instr_f", instr_f, e_instr);
    chk("pc_out_f", pc_out_f, m_pc);
    chk("pc_plus4_f", pc_plus4_f, m_pc + 32'd4);
    chk("fetch_timeout", fetch_timeout, m_flag);
    s_valid = valid_f; s_instr = instr_f; s_pc = pc_out_f; s_pc4 = pc_plus4_f;

    c = (e_req && !ack) ? ((m_cnt >= TO) ? TO : m_cnt + 1) : 0;
    m_cnt = c;
    if (c == TO) m_flag = 1;
    if (!m_started) begin
      m_started = 1;
    end else if (m_held) begin
      if (src) begin m_pc = tgt; m_held = 0; end
      else if (!stl) begin m_pc = m_pc + 32'd4; m_held = 0; end
    end else if (m_disc) begin
      if (src) m_pc = tgt;
      if (ack) m_disc = 0;
    end else if (ack) begin
      if (src) m_pc = tgt;
      else if (!stl) m_pc = m_pc + 32'd4;
      else begin m_held = 1; m_word = rd; end
    end else if (src) begin
      m_drop = m_pc; m_disc = 1; m_pc = tgt;
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_cycle();
    bit          ack, src, stl;
    logic [31:0] tgt;
    ack = 0;
    if (imem.mem_req) begin
      if (!mb) begin
        mb = 1;
        ml = ($urandom_range(0, 15) == 0) ? 18 : $urandom_range(0, 3);
      end
      ack = (ml == 0);
      if (ack) mb = 0; else ml--;
    end else begin
      mb = 0;
    end
    src = ($urandom_range(0, 7) == 0);
    tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
    stl = ($urandom_range(0, 2) == 0);
    step(ack, $urandom, src, tgt, stl);
  endtask

  initial begin
    reset = 1'b0; pc_src_e = 0; pc_target_e = 0; stall_d = 0;
    imem.mem_ack = 0; imem.mem_rdata = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst mem_req", imem.mem_req, 1'b0);
    chk("rst valid_f", valid_f, 1'b0);
    chk("rst instr_f", instr_f, NOP);
    chk("rst timeout", fetch_timeout, 1'b0);
    chk("rst pc_out_f", pc_out_f, 32'h0);
    chk("rst pc_plus4", pc_plus4_f, 32'h4);
    reset = 1'b1;
    step(0, 0, 0, 0, 0);

    // Zero-wait memory: one instruction per cycle
    for (int i = 0; i < 4; i++) begin
      chk("A addr", imem.mem_addr, i * 4);
      step(1, 32'hA000_0000 + i, 0, 0, 0);
      chk("A valid", s_valid, 1'b1);
      chk("A instr", s_instr, 32'hA000_0000 + i);
      chk("A pc4", s_pc4, i * 4 + 4);
    end

    // Redirect while the fetch of 0x10 is outstanding
    chk("B addr0", imem.mem_addr, 32'h10);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h100, 0);
    chk("B valid redirect", s_valid, 1'b0);
    chk("B addr held1", imem.mem_addr, 32'h10);
    step(0, 0, 0, 0, 0);
    chk("B addr held2", imem.mem_addr, 32'h10);
    step(1, 32'hDEAD_BEEF, 0, 0, 0);
    chk("B discard valid", s_valid, 1'b0);
    chk("B discard instr", s_instr, NOP);
    chk("B next addr", imem.mem_addr, 32'h100);

    // Three-cycle memory latency
    step(0, 0, 0, 0, 0);
    chk("C wait valid", s_valid, 1'b0);
    chk("C addr", imem.mem_addr, 32'h100);
    step(0, 0, 0, 0, 0);
    chk("C addr2", imem.mem_addr, 32'h100);
    step(1, 32'h1234_5678, 0, 0, 0);
    chk("C valid", s_valid, 1'b1);
    chk("C instr", s_instr, 32'h1234_5678);
    chk("C pc", s_pc, 32'h100);

    // Stall on return goes through the hold buffer
    chk("D addr", imem.mem_addr, 32'h104);
    step(1, 32'hCAFE_0001, 0, 0, 1);
    chk("D ack valid", s_valid, 1'b0);
    chk("D hold req", imem.mem_req, 1'b0);
    step(0, 0, 0, 0, 1);
    chk("D hold valid", s_valid, 1'b1);
    chk("D hold instr", s_instr, 32'hCAFE_0001);
    chk("D hold pc", s_pc, 32'h104);
    step(0, 0, 0, 0, 0);
    chk("D consume instr", s_instr, 32'hCAFE_0001);
    chk("D next req", imem.mem_req, 1'b1);
    chk("D next addr", imem.mem_addr, 32'h108);

    // Redirect coincident with ack, redirect in HOLD, PC wrap
    step(1, 32'hBAD0_0001, 1, 32'h200, 0);
    chk("E ack+redirect valid", s_valid, 1'b0);
    chk("E addr", imem.mem_addr, 32'h200);
    step(1, 32'h2000_0000, 0, 0, 1);
    step(0, 0, 1, 32'h300, 1);
    chk("E hold redirect valid", s_valid, 1'b0);
    chk("E hold redirect addr", imem.mem_addr, 32'h300);
    step(1, 32'hBAD0_0002, 1, 32'hFFFF_FFFC, 0);
    chk("E wrap addr", imem.mem_addr, 32'hFFFF_FFFC);
    step(1, 32'h7777_0000, 0, 0, 0);
    chk("E wrap valid", s_valid, 1'b1);
    chk("E wrap pc", s_pc, 32'hFFFF_FFFC);
    chk("E wrap pc4", s_pc4, 32'h0);
    chk("E wrap next addr", imem.mem_addr, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) rand_cycle();

    // Memory that never acks
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) step(0, 0, 0, 0, 0);
    chk("G timeout early", fetch_timeout, 1'b0);
    step(0, 0, 0, 0, 0);
    chk("G timeout set", fetch_timeout, 1'b1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    chk("G timeout sticky", fetch_timeout, 1'b1);
    chk("G addr stuck", imem.mem_addr, 32'h0);

    // Asynchronous reset in the middle of a wait
    #2 reset = 1'b0;
    #1;
    chk("G async timeout", fetch_timeout, 1'b0);
    chk("G async req", imem.mem_req, 1'b0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    step(0, 0, 0, 0, 0);
    chk("G restart req", imem.mem_req, 1'b1);
    chk("G restart addr", imem.mem_addr, 32'h0);
    step(1, 32'h0000_0093, 0, 0, 0);
    chk("G restart valid", s_valid, 1'b1);
    chk("G restart pc", s_pc, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
